fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Upstream neighbour of the instruction memory. Owns the program counter and drives the memory's word-aligned byte address. It waits a fixed number of cycles for the combinational-with-delay memory output to settle, then captures the instruction with its PC into a small FIFO. The FIFO feeds the decode stage over a valid/ready handshake. A redirect (branch/jump) flushes in-flight and buffered work and restarts fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned
MEM_LATENCY, 2, clock cycles the address is held stable before the instruction is sampled; range 1..15
FIFO_DEPTH, 2, fetch buffer entries; power of 2, at least 2

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
read_address  output  32  byte address to instruction memory; bits [1:0] always 0
instruction  input  32  instruction word from memory
redirect  input  1  one-cycle pulse: flush and refetch from redirect_target
redirect_target  input  32  new PC; bits [1:0] ignored (treated as 0)
instr_valid  output  1  FIFO head valid
instr_out  output  32  FIFO head instruction
pc_out  output  32  FIFO head PC
instr_ready  input  1  decode accepts head this cycle
pc_plus4_out  output  32  pc_out + 4 (mod 2^32), for link/branch use

Behaviour:
- Reset (reset_n low, asynchronous):
  - pc = RESET_PC; read_address = RESET_PC.
  - wait counter = MEM_LATENCY; FIFO emptied.
  - instr_valid = 0; instr_out = 0; pc_out = 0; pc_plus4_out = 4.
  - Assertion at any time, including mid-wait or with a full FIFO, aborts everything; no partial state survives.
- read_address is a registered copy of pc. It changes only on reset, PC advance, or redirect.
- States: WAIT, FULL_HOLD.
  - WAIT: each edge with counter > 0, counter decrements.
  - WAIT with counter == 0:
    - If a push is allowed, on that edge push {pc, instruction}, pc += 4, counter = MEM_LATENCY, stay in WAIT.
    - Otherwise go to FULL_HOLD. pc and address are unchanged.
  - FULL_HOLD: remain while a push is not allowed. The address is held, so the data stays settled.
  - FULL_HOLD, on the first edge a push is allowed: push and advance as above, then go to WAIT.
- Push allowed when FIFO count < FIFO_DEPTH, or a pop occurs the same edge (pass-through when full).
- Timing (MEM_LATENCY=2, empty FIFO, instr_ready=1):
  - Reset released before edge 1.
  - Edges 1 and 2 decrement the counter; edge 3 captures.
  - instr_valid rises after edge 3. Thereafter throughput is one instruction per MEM_LATENCY+1 cycles.
- Pop: when instr_valid && instr_ready on an edge, the head is removed. The next entry, if any, appears after that edge.
- Outputs are stable while instr_valid=1 and instr_ready=0.
- Redirect (highest priority, overrides push and pop in the same edge):
  - FIFO flushed; instr_valid = 0 after the edge.
  - pc = read_address = {redirect_target[31:2], 2'b00}; counter = MEM_LATENCY; state = WAIT.
  - An instruction being captured that same edge is discarded.
  - A pop coinciding with redirect counts as accepted by decode (decode is responsible for squashing).
  - Back-to-back redirects: the last one wins and the counter restarts each time.
- Arithmetic: pc += 4 wraps from 32'hFFFF_FFFC to 32'h0000_0000, with no flag. pc_plus4_out wraps identically.
- The FIFO uses pointers one bit wider than log2(FIFO_DEPTH). Full and empty are distinguished by the MSB; pointers wrap naturally.

Test Plan:
- Reset, then free-run with instr_ready=1, mem[0..3]=A,B,C,D.
  - instr_valid first high after edge 3.
  - pc_out sequence 0,4,8,C with instr_out A,B,C,D, each MEM_LATENCY+1 cycles apart.
- instr_ready=0 for 20 cycles.
  - FIFO fills with 2 entries; state goes to FULL_HOLD; read_address frozen at 8.
  - Raising ready drains PC 0, then 4, then a fresh fetch of 8; no instruction is lost or duplicated.
- redirect=1 with target 32'h0000_0043 while FIFO holds 2 entries and counter==0.
  - Next cycle instr_valid=0 and read_address=32'h40.
  - The next output is pc_out=40 after MEM_LATENCY+1 edges; the captured-but-discarded word never appears.
- RESET_PC=32'hFFFF_FFF8, free-run.
  - pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - pc_plus4_out at FFFF_FFFC is 0.
- Assert reset_n low asynchronously mid-wait with a full FIFO and instr_ready=0.
  - instr_valid=0 and read_address=RESET_PC immediately, without a clock edge.
  - After release, the normal first-fetch timing repeats.
- Full FIFO, instr_ready=1 exactly on the capture edge.
  - Simultaneous pop and push; count stays at FIFO_DEPTH; no stall cycle is inserted.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: instruction-memory address/data, redirect request and
// the decode valid/ready handshake carrying the buffered instruction and PC.
interface fetch_unit_if;
   logic [31:0] read_address;
   logic [31:0] instruction;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_ready;
   logic [31:0] pc_plus4_out;

   modport master (
      output read_address, instr_valid, instr_out, pc_out, pc_plus4_out,
      input  instruction, redirect, redirect_target, instr_ready
   );

   modport slave (
      input  read_address, instr_valid, instr_out, pc_out, pc_plus4_out,
      output instruction, redirect, redirect_target, instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, holds the memory address for MEM_LATENCY
// cycles, then captures {pc, instruction} into a small decode-facing FIFO.
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input logic          clk,
   input logic          reset_n,
   fetch_unit_if.master bus
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam logic [3:0]  LAT = 4'(MEM_LATENCY);

   localparam logic [0:0] STATE_WAIT      = 1'b0;
   localparam logic [0:0] STATE_FULL_HOLD = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   logic [31:0] instr_mem [FIFO_DEPTH];
   logic [31:0] pc_mem    [FIFO_DEPTH];

   logic fifo_empty, fifo_full, pop, capture, push_ok, push;
   logic [31:0] head_pc;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = !fifo_empty && bus.instr_ready;
      // FULL_HOLD is only entered with the counter already at zero
      capture    = (state_q == STATE_FULL_HOLD) || (cnt_q == 4'd0);
      push_ok    = !fifo_full || pop;
      push       = capture && push_ok && !bus.redirect;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (bus.redirect) begin
         pc_d     = bus.redirect_target & ~32'h3;
         cnt_d    = LAT;
         state_d  = STATE_WAIT;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         if (capture) begin
            if (push_ok) begin
               wr_ptr_d = wr_ptr_q + (AW+1)'(1);
               pc_d     = pc_q + 32'd4;
               cnt_d    = LAT;
               state_d  = STATE_WAIT;
            end else begin
               state_d  = STATE_FULL_HOLD;
            end
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= STATE_WAIT;
         cnt_q    <= LAT;
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q[AW-1:0]] <= bus.instruction;
         pc_mem[wr_ptr_q[AW-1:0]]    <= pc_q;
      end
   end

   // Empty FIFO presents zeros so outputs are defined straight out of reset
   assign head_pc          = fifo_empty ? '0 : pc_mem[rd_ptr_q[AW-1:0]];
   assign bus.instr_out    = fifo_empty ? '0 : instr_mem[rd_ptr_q[AW-1:0]];
   assign bus.pc_out       = head_pc;
   assign bus.pc_plus4_out = head_pc + 32'd4;
   assign bus.instr_valid  = !fifo_empty;
   assign bus.read_address = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: first-fetch timing, back-pressure, redirect,
// PC wrap (second instance) and asynchronous reset.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   fetch_unit_if bus_a ();
   fetch_unit_if bus_b ();

   function automatic logic [31:0] memword(input logic [31:0] a);
      case (a)
         32'h0:   memword = 32'hAAAA_0001;
         32'h4:   memword = 32'hBBBB_0002;
         32'h8:   memword = 32'hCCCC_0003;
         32'hC:   memword = 32'hDDDD_0004;
         default: memword = a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign bus_a.instruction     = memword(bus_a.read_address);
   assign bus_b.instruction     = memword(bus_b.read_address);
   assign bus_b.redirect        = 1'b0;
   assign bus_b.redirect_target = 32'h0;
   assign bus_b.instr_ready     = 1'b1;

   fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(2), .FIFO_DEPTH(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MEM_LATENCY(2), .FIFO_DEPTH(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse reset mid-cycle; release lands well before the next rising edge.
   task automatic do_reset(input logic ready);
      @(posedge clk);
      #3 reset_n = 1'b0;
      bus_a.redirect        = 1'b0;
      bus_a.redirect_target = 32'h0;
      bus_a.instr_ready     = ready;
      #3 reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] eb;
      bus_a.redirect        = 1'b0;
      bus_a.redirect_target = 32'h0;
      bus_a.instr_ready     = 1'b1;

      // Free run from reset
      do_reset(1'b1);
      check("rst_valid", 32'(bus_a.instr_valid), 32'h0);
      check("rst_instr", bus_a.instr_out, 32'h0);
      check("rst_pc", bus_a.pc_out, 32'h0);
      check("rst_pc4", bus_a.pc_plus4_out, 32'h4);
      check("rst_addr", bus_a.read_address, 32'h0);
      check("rst_addr_b", bus_b.read_address, 32'hFFFF_FFF8);
      for (int unsigned k = 1; k <= 4; k++) begin
         step(2);
         check("run_valid_lo", 32'(bus_a.instr_valid), 32'h0);
         step(1);
         check("run_valid_hi", 32'(bus_a.instr_valid), 32'h1);
         check("run_pc", bus_a.pc_out, 32'(4 * (k - 1)));
         check("run_instr", bus_a.instr_out, memword(32'(4 * (k - 1))));
         check("run_pc4", bus_a.pc_plus4_out, 32'(4 * k));
         if (k <= 3) begin
            eb = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
            check("wrap_pc", bus_b.pc_out, eb);
            check("wrap_pc4", bus_b.pc_plus4_out, eb + 32'd4);
         end
      end

      // Back-pressure: FIFO fills, address freezes, then drains in order
      do_reset(1'b0);
      step(20);
      check("bp_valid", 32'(bus_a.instr_valid), 32'h1);
      check("bp_pc", bus_a.pc_out, 32'h0);
      check("bp_addr", bus_a.read_address, 32'h8);
      bus_a.instr_ready = 1'b1;
      step(1);
      check("drain1_pc", bus_a.pc_out, 32'h4);
      check("drain1_addr", bus_a.read_address, 32'hC);
      step(1);
      check("drain2_pc", bus_a.pc_out, 32'h8);
      check("drain2_instr", bus_a.instr_out, memword(32'h8));
      step(1);
      check("drain3_valid", 32'(bus_a.instr_valid), 32'h0);
      step(1);
      check("drain4_pc", bus_a.pc_out, 32'hC);
      check("drain4_instr", bus_a.instr_out, memword(32'hC));

      // Ready only on the capture edge with a full FIFO: pass-through
      do_reset(1'b0);
      step(8);
      bus_a.instr_ready = 1'b1;
      step(1);
      bus_a.instr_ready = 1'b0;
      check("pt_pc", bus_a.pc_out, 32'h4);
      check("pt_addr", bus_a.read_address, 32'hC);
      step(5);
      check("pt_hold_addr", bus_a.read_address, 32'hC);
      check("pt_hold_pc", bus_a.pc_out, 32'h4);

      // Redirect with full FIFO and counter at zero
      do_reset(1'b0);
      step(8);
      bus_a.redirect        = 1'b1;
      bus_a.redirect_target = 32'h0000_0043;
      step(1);
      bus_a.redirect    = 1'b0;
      bus_a.instr_ready = 1'b1;
      check("rd_valid", 32'(bus_a.instr_valid), 32'h0);
      check("rd_addr", bus_a.read_address, 32'h40);
      step(2);
      check("rd_wait_valid", 32'(bus_a.instr_valid), 32'h0);
      step(1);
      check("rd_pc", bus_a.pc_out, 32'h40);
      check("rd_instr", bus_a.instr_out, memword(32'h40));

      // Back-to-back redirects: the last one wins, counter restarts
      step(1);
      bus_a.redirect        = 1'b1;
      bus_a.redirect_target = 32'h0000_0100;
      step(1);
      bus_a.redirect_target = 32'h0000_0206;
      step(1);
      bus_a.redirect = 1'b0;
      check("b2b_addr", bus_a.read_address, 32'h204);
      step(2);
      check("b2b_wait_valid", 32'(bus_a.instr_valid), 32'h0);
      step(1);
      check("b2b_pc", bus_a.pc_out, 32'h204);

      // Asynchronous reset mid-wait with a full FIFO
      do_reset(1'b0);
      step(7);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus_a.instr_valid), 32'h0);
      check("arst_addr", bus_a.read_address, 32'h0);
      check("arst_pc4", bus_a.pc_plus4_out, 32'h4);
      #2 reset_n = 1'b1;
      step(2);
      check("arst_wait_valid", 32'(bus_a.instr_valid), 32'h0);
      step(1);
      check("arst_first_valid", 32'(bus_a.instr_valid), 32'h1);
      check("arst_first_pc", bus_a.pc_out, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
